// File: rtl/wd_tx_frame_ctrl.sv
// Watchdog TX frame sequencer: streams tx_len buffer bytes followed by a 2-byte FCS16 trailer.
// Latency: first payload byte valid 3 cycles after tx_req accept, then 3 cycles per byte, FCS bytes back-to-back.
// Backpressure: tx_rdy low holds the current byte (data stable); optional stall timeout aborts the frame.
//
// Optional feature macro: WD_TX_RDY_TMO_EN (ready-stall timeout of TMO_CYC cycles).
//
// Ports:
//   clk_sys, rst_sys_n             clock, asynchronous active-low reset
//   tx_req, tx_len                 frame request and payload length (sampled in IDLE)
//   tx_busy, tx_done, tx_err       scheduler status (done/err are 1-cycle pulses)
//   pld_rd_en, pld_rd_addr         frame buffer read port (1-cycle read latency)
//   pld_rd_data                    frame buffer read data
//   crc_sop, crc_din, crc_din_vld  FCS16 engine init / data / update strobe
//   crc_cap, crc_dout              FCS16 engine capture strobe / captured value
//   tx_data, tx_vld, tx_sof,
//   tx_eof, tx_rdy                 output byte stream (valid/ready)

module wd_tx_frame_ctrl #(
    parameter int LEN_W   = 8,
    parameter int TMO_CYC = 1024
) (
    input  logic             clk_sys,
    input  logic             rst_sys_n,
    input  logic             tx_req,
    input  logic [LEN_W-1:0] tx_len,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_err,
    output logic             pld_rd_en,
    output logic [LEN_W-1:0] pld_rd_addr,
    input  logic [7:0]       pld_rd_data,
    output logic             crc_sop,
    output logic [7:0]       crc_din,
    output logic             crc_din_vld,
    output logic             crc_cap,
    input  logic [15:0]      crc_dout,
    output logic [7:0]       tx_data,
    output logic             tx_vld,
    output logic             tx_sof,
    output logic             tx_eof,
    input  logic             tx_rdy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOP,
        S_WT,
        S_SEND,
        S_RD,
        S_FCS_HI,
        S_FCS_LO
    } state_t;

    localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic [7:0]       r_byte;
    logic             r_tx_vld;
    logic             r_tx_sof;
    logic             r_tx_eof;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_crc_sop;
    logic             r_rd_en;
    logic [LEN_W-1:0] r_rd_addr;

    logic             w_hs;
    logic             w_last;
    logic             w_din_vld;
    logic             w_tmo;
    logic [7:0]       w_tx_data;

    assign w_hs      = r_tx_vld & tx_rdy;
    assign w_last    = (r_idx == (r_len - ONE));
    assign w_din_vld = (r_state == S_SEND) & w_hs;

    // The FCS is captured by the engine on the same edge that leaves SEND,
    // so the trailer bytes are taken straight from crc_dout rather than
    // through r_byte; crc_dout holds while we stall.
    always_comb begin
        w_tx_data = r_byte;
        case (r_state)
            S_FCS_HI: w_tx_data = crc_dout[15:8];
            S_FCS_LO: w_tx_data = crc_dout[7:0];
            default:  w_tx_data = r_byte;
        endcase
    end

`ifdef WD_TX_RDY_TMO_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);

    logic [CNT_W-1:0] r_stall_cnt;

    // Abort on the TMO_CYC-th consecutive stall cycle.
    assign w_tmo = r_tx_vld & ~tx_rdy & (r_stall_cnt == CNT_W'(TMO_CYC - 1));

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_stall_cnt <= '0;
        end else if (!r_tx_vld || tx_rdy) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
`else
    logic w_unused_tmo;

    assign w_tmo        = 1'b0;
    assign w_unused_tmo = (TMO_CYC != 0);
`endif

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_idx     <= '0;
            r_byte    <= '0;
            r_tx_vld  <= 1'b0;
            r_tx_sof  <= 1'b0;
            r_tx_eof  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_crc_sop <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            // Single-cycle strobes default low.
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_crc_sop <= 1'b0;
            r_rd_en   <= 1'b0;

            if (w_tmo) begin
                r_tx_vld <= 1'b0;
                r_tx_sof <= 1'b0;
                r_tx_eof <= 1'b0;
                r_err    <= 1'b1;
                r_busy   <= 1'b0;
                r_state  <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (tx_req) begin
                            if (tx_len == '0) begin
                                r_err <= 1'b1;
                            end else begin
                                r_len     <= tx_len;
                                r_idx     <= '0;
                                r_busy    <= 1'b1;
                                r_crc_sop <= 1'b1;
                                r_rd_en   <= 1'b1;
                                r_rd_addr <= '0;
                                r_state   <= S_SOP;
                            end
                        end
                    end
                    S_SOP: begin
                        r_state <= S_WT;
                    end
                    S_WT: begin
                        r_byte   <= pld_rd_data;
                        r_tx_vld <= 1'b1;
                        r_tx_sof <= (r_idx == '0);
                        r_state  <= S_SEND;
                    end
                    S_SEND: begin
                        if (tx_rdy) begin
                            r_tx_sof <= 1'b0;
                            if (w_last) begin
                                // Valid stays high: the FCS high byte follows immediately.
                                r_state <= S_FCS_HI;
                            end else begin
                                r_tx_vld  <= 1'b0;
                                r_idx     <= r_idx + ONE;
                                r_rd_en   <= 1'b1;
                                r_rd_addr <= r_idx + ONE;
                                r_state   <= S_RD;
                            end
                        end
                    end
                    S_RD: begin
                        r_state <= S_WT;
                    end
                    S_FCS_HI: begin
                        if (tx_rdy) begin
                            r_tx_eof <= 1'b1;
                            r_state  <= S_FCS_LO;
                        end
                    end
                    S_FCS_LO: begin
                        if (tx_rdy) begin
                            r_tx_vld <= 1'b0;
                            r_tx_eof <= 1'b0;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_busy     = r_busy;
    assign tx_done     = r_done;
    assign tx_err      = r_err;
    assign pld_rd_en   = r_rd_en;
    assign pld_rd_addr = r_rd_addr;
    assign crc_sop     = r_crc_sop;
    assign crc_din     = w_tx_data;
    assign crc_din_vld = w_din_vld;
    assign crc_cap     = w_din_vld & w_last;
    assign tx_data     = w_tx_data;
    assign tx_vld      = r_tx_vld;
    assign tx_sof      = r_tx_sof;
    assign tx_eof      = r_tx_eof;

endmodule
